// File: rtl/tx_arbiter.sv
// Two-source byte arbiter in front of the character transmitter: round-robin per
// message, grant held until a byte marked last completes, watchdog abort in WAIT.
module tx_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       src0_valid,
    input  logic [7:0] src0_data,
    input  logic       src0_last,
    output logic       src0_ack,
    input  logic       src1_valid,
    input  logic [7:0] src1_data,
    input  logic       src1_last,
    output logic       src1_ack,
    output logic [7:0] Data,
    output logic       Data_rdy,
    input  logic       transEna,
    output logic       busy,
    output logic       owner,
    output logic       err,
    output logic [2:0] dbg_state_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          lock_q, lock_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic [7:0]    data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant;
    logic          grant_src;
    logic          owner_last;

    // A locked owner is served exclusively; otherwise rr breaks ties.
    always_comb begin
        grant     = 1'b0;
        grant_src = rr_q;
        if (lock_q) begin
            grant_src = owner_q;
            grant     = owner_q ? src1_valid : src0_valid;
        end else if (src0_valid && src1_valid) begin
            grant_src = rr_q;
            grant     = 1'b1;
        end else if (src0_valid) begin
            grant_src = 1'b0;
            grant     = 1'b1;
        end else if (src1_valid) begin
            grant_src = 1'b1;
            grant     = 1'b1;
        end
    end

    assign owner_last = owner_q ? src1_last : src0_last;

    // All state moves on the falling edge to line up with the transmitter.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    data_d  = grant_src ? src1_data : src0_data;
                    owner_d = grant_src;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion on the timeout edge still counts as success.
                if (transEna) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_ACK: begin
                if (owner_last) begin
                    lock_d = 1'b0;
                    rr_d   = ~owner_q;
                end else begin
                    lock_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_ABORT: begin
                lock_d  = 1'b0;
                rr_d    = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Data_rdy    = (state_q == S_SEND);
        src0_ack    = (state_q == S_ACK) && !owner_q;
        src1_ack    = (state_q == S_ACK) && owner_q;
        err         = (state_q == S_ABORT);
        busy        = (state_q != S_IDLE);
        Data        = data_q;
        owner       = owner_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios plus randomized messages, checked against
// a transaction-level model of the round-robin/lock/watchdog rules.
module tb_tx_arbiter;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       src0_valid = 1'b0, src0_last = 1'b0, src0_ack;
  logic [7:0] src0_data = 8'h00;
  logic       src1_valid = 1'b0, src1_last = 1'b0, src1_ack;
  logic [7:0] src1_data = 8'h00;
  logic [7:0] Data;
  logic       Data_rdy, busy, owner, err;
  logic       transEna = 1'b0;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Pending bytes per source as {last, data}; front entry drives the inputs.
  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];
  // Expected transmissions as {source, data}, with completion delay per attempt.
  logic [8:0] exp_q[$];
  int         k_exp_q[$];
  int         plan_q[$];

  tx_arbiter #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src0_valid (src0_valid),
    .src0_data  (src0_data),
    .src0_last  (src0_last),
    .src0_ack   (src0_ack),
    .src1_valid (src1_valid),
    .src1_data  (src1_data),
    .src1_last  (src1_last),
    .src1_ack   (src1_ack),
    .Data       (Data),
    .Data_rdy   (Data_rdy),
    .transEna   (transEna),
    .busy       (busy),
    .owner      (owner),
    .err        (err),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    src0_valid = (src0_q.size() > 0);
    src1_valid = (src1_q.size() > 0);
    if (src0_valid) {src0_last, src0_data} = src0_q[0];
    else            {src0_last, src0_data} = 9'h000;
    if (src1_valid) {src1_last, src1_data} = src1_q[0];
    else            {src1_last, src1_data} = 9'h000;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"}, Data, 8'h00);
    check({tag, "_rdy"}, Data_rdy, 0);
    check({tag, "_acks"}, {src1_ack, src0_ack}, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_owner"}, owner, 0);
  endtask

  // Leaves time just after a falling edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    transEna = 1'b0;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    k_exp_q.delete();
    drive_src();
    #1;
    check_reset("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Transaction-level reference: walk the message queues applying the arbitration rules.
  task automatic build_expected();
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] b;
    bit lock, own, rr, sel;
    int k, guard;
    q0 = src0_q;
    q1 = src1_q;
    lock = 0; own = 0; rr = 0; guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 200) begin
      guard++;
      if (lock)                               sel = own;
      else if (q0.size() > 0 && q1.size() > 0) sel = rr;
      else                                    sel = (q1.size() > 0);
      if (sel) b = q1[0];
      else     b = q0[0];
      if (plan_q.size() > 0) k = plan_q.pop_front();
      else                   k = int'($urandom_range(1, T + 1));
      exp_q.push_back({sel, b[7:0]});
      k_exp_q.push_back(k);
      own = sel;
      if (k <= T) begin
        if (sel) void'(q1.pop_front());
        else     void'(q0.pop_front());
        if (b[8]) begin lock = 0; rr = ~sel; end
        else      lock = 1;
      end else begin
        lock = 0;
        rr = ~sel;
      end
    end
  endtask

  // Plays the transmitter for each expected attempt; k = WAIT cycle carrying transEna, k > T = none.
  task automatic run_all(input bit spurious_send);
    logic [8:0] e;
    int k;
    bit s, done;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k = k_exp_q.pop_front();
      s = e[8];
      @(posedge clk);
      check("idle_busy", busy, 0);
      check("idle_rdy", Data_rdy, 0);
      @(posedge clk);
      check("send_rdy", Data_rdy, 1);
      check("send_data", Data, e[7:0]);
      check("send_owner", owner, s);
      check("send_busy", busy, 1);
      #1 transEna = spurious_send;
      done = 0;
      for (int j = 1; j <= T + 1 && !done; j++) begin
        @(posedge clk);
        if (k <= T && j == k + 1) begin
          check("ack", {src1_ack, src0_ack}, s ? 2'b10 : 2'b01);
          check("ack_err", err, 0);
          check("ack_data_hold", Data, e[7:0]);
          done = 1;
        end else if (k > T && j == T + 1) begin
          check("abort_err", err, 1);
          check("abort_acks", {src1_ack, src0_ack}, 0);
          done = 1;
        end else begin
          check("wait_acks", {src1_ack, src0_ack}, 0);
          check("wait_err", err, 0);
          check("wait_rdy", Data_rdy, 0);
          check("wait_busy", busy, 1);
        end
        #1 transEna = (k <= T) && (j == k) && !done;
      end
      transEna = 1'b0;
      @(negedge clk);
      #1;
      if (k <= T) begin
        if (s) void'(src1_q.pop_front());
        else   void'(src0_q.pop_front());
        drive_src();
      end
    end
  endtask

  initial begin
    int nmsg, len;

    // Single byte from source 0, completion three WAIT cycles in.
    do_reset();
    src0_q.push_back(9'h141);
    drive_src();
    plan_q = '{3};
    build_expected();
    run_all(0);
    repeat (3) begin
      @(posedge clk);
      check("single_after_busy", busy, 0);
      check("single_after_acks", {src1_ack, src0_ack}, 0);
      check("single_after_err", err, 0);
    end
    #1;

    // Fair contention: single-byte messages from both, always valid.
    @(negedge clk);
    do_reset();
    src0_q = '{9'h131, 9'h131};
    src1_q = '{9'h132, 9'h132};
    drive_src();
    plan_q = '{1, 2, 1, 2};
    build_expected();
    run_all(0);

    // Message lock: three-byte message from source 0 while source 1 waits.
    do_reset();
    src0_q = '{9'h048, 9'h049, 9'h10D};
    src1_q = '{9'h139};
    drive_src();
    plan_q = '{2, 2, 2, 2};
    build_expected();
    run_all(0);

    // Watchdog: first attempt times out, retry completes on the timeout edge.
    do_reset();
    src1_q = '{9'h155};
    drive_src();
    plan_q = '{T + 1, T};
    build_expected();
    run_all(0);

    // Spurious completion in IDLE, then during SEND.
    do_reset();
    @(posedge clk);
    #1 transEna = 1'b1;
    @(posedge clk);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_acks", {src1_ack, src0_ack}, 0);
    check("spur_idle_err", err, 0);
    #1 transEna = 1'b0;
    @(negedge clk);
    #1;
    src0_q = '{9'h17A};
    drive_src();
    plan_q = '{3};
    build_expected();
    run_all(1);

    // Reset while waiting on a source 1 byte; afterwards source 0 wins first.
    do_reset();
    src1_q = '{9'h1A1};
    drive_src();
    @(posedge clk);
    @(posedge clk);
    check("rw_rdy", Data_rdy, 1);
    check("rw_data", Data, 8'hA1);
    check("rw_owner", owner, 1);
    @(posedge clk);
    check("rw_wait_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset("rw_async");
    src0_q = '{9'h130};
    drive_src();
    @(negedge clk);
    #1 rst_n = 1'b1;
    build_expected();
    run_all(0);

    // Randomized messages with random completion delays and occasional timeouts.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int s = 0; s < 2; s++) begin
        nmsg = int'($urandom_range(1, 3));
        for (int m = 0; m < nmsg; m++) begin
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) begin
            if (s == 0) src0_q.push_back({b == len - 1, 8'($urandom_range(0, 255))});
            else        src1_q.push_back({b == len - 1, 8'($urandom_range(0, 255))});
          end
        end
      end
      drive_src();
      build_expected();
      run_all(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
